// File: rtl/exec_result_queue.sv
// exec_result_queue
// Execute-to-writeback staging queue. Holds up to DEPTH execute results in a
// circular buffer with valid/ready handshakes on both sides, owns the
// architectural flags register (masked update on every accepted result) and
// emits a one-cycle branch-redirect pulse for accepted redirecting results.
//
// Optional build macro: EXEC_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards in_data straight to out_data in the
//   same cycle; if writeback takes it, the entry is never written.
//   When undefined, out_valid depends only on the occupancy count.

module exec_result_queue #(
   parameter int               WIDTH       = 190,
   parameter int               DEPTH       = 4,
   parameter int               FLAGW       = 7,
   parameter logic [FLAGW-1:0] FLAGS_RESET = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [FLAGW-1:0]           in_flags,
   input  logic [FLAGW-1:0]           in_flag_mask,
   input  logic                       in_redirect,
   input  logic [31:0]                in_redirect_addr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [FLAGW-1:0]           flags_out,
   output logic                       redirect_valid,
   output logic [31:0]                redirect_addr,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   logic             enq;
   logic             wr_en;
   logic             rd_en;
   logic             empty;

   assign empty    = (count_q == '0);
   assign count    = count_q;

   // in_ready looks only at the registered count, so a dequeue on a full
   // queue frees the slot for the following cycle, never the current one.
   assign in_ready = (count_q != FULL_CNT);

   // Accepted result: drives the write, the flags update and the redirect.
   assign enq      = in_valid & in_ready & ~flush;

`ifdef EXEC_QUEUE_BYPASS_EN
   logic bypass_hit;
   logic pass_thru;

   // Empty queue with a live input presents that input directly.
   assign bypass_hit = empty & in_valid & ~flush;
   assign pass_thru  = bypass_hit & out_ready;

   assign out_valid  = ~empty | bypass_hit;
   assign out_data   = bypass_hit ? in_data : mem[rd_ptr];

   // A result consumed in the same cycle it arrives never occupies a slot.
   assign wr_en      = enq & ~pass_thru;
   assign rd_en      = ~empty & out_ready & ~flush;
`else
   assign out_valid  = ~empty;
   assign out_data   = mem[rd_ptr];

   assign wr_en      = enq;
   assign rd_en      = out_valid & out_ready & ~flush;
`endif

   // Payload storage; contents are don't-care after reset or flush.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Architectural flags: masked merge on each accepted result, kept across flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_out <= FLAGS_RESET;
      end else if (enq) begin
         flags_out <= (flags_out & ~in_flag_mask) | (in_flags & in_flag_mask);
      end
   end

   // Redirect pulse lasts one cycle; the target holds until the next redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_valid <= 1'b0;
         redirect_addr  <= '0;
      end else begin
         redirect_valid <= enq & in_redirect;
         if (enq & in_redirect) begin
            redirect_addr <= in_redirect_addr;
         end
      end
   end

endmodule

// File: tb/tb_exec_result_queue.sv
module tb_exec_result_queue;

   localparam int WIDTH = 190;
   localparam int DEPTH = 4;
   localparam int FLAGW = 7;
   localparam int CW    = $clog2(DEPTH+1);
   localparam logic [FLAGW-1:0] FLAGS_RESET = 7'h00;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [FLAGW-1:0] in_flags = '0;
   logic [FLAGW-1:0] in_flag_mask = '0;
   logic             in_redirect = 1'b0;
   logic [31:0]      in_redirect_addr = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [FLAGW-1:0] flags_out;
   logic             redirect_valid;
   logic [31:0]      redirect_addr;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_errors = 0;

   exec_result_queue #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FLAGW(FLAGW), .FLAGS_RESET(FLAGS_RESET)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_flags(in_flags), .in_flag_mask(in_flag_mask),
      .in_redirect(in_redirect), .in_redirect_addr(in_redirect_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flags_out(flags_out), .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   logic [WIDTH-1:0] mq[$];
   logic [FLAGW-1:0] m_flags = FLAGS_RESET;
   logic             m_rv = 1'b0;
   logic [31:0]      m_ra = '0;
   logic             m_acc;
   logic             m_pass;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_flags = FLAGS_RESET;
         m_rv    = 1'b0;
         m_ra    = '0;
      end else if (flush) begin
         mq.delete();
         m_rv = 1'b0;
      end else begin
         m_acc  = in_valid && (mq.size() < DEPTH);
         m_pass = 1'b0;
`ifdef EXEC_QUEUE_BYPASS_EN
         m_pass = m_acc && (mq.size() == 0) && out_ready;
`endif
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (m_acc && !m_pass) mq.push_back(in_data);
         if (m_acc) m_flags = (m_flags & ~in_flag_mask) | (in_flags & in_flag_mask);
         m_rv = m_acc && in_redirect;
         if (m_rv) m_ra = in_redirect_addr;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic             e_valid;
   logic [WIDTH-1:0] e_data;

   always @(negedge clk) begin
      if (reset) begin
         e_valid = (mq.size() != 0);
         e_data  = (mq.size() != 0) ? mq[0] : '0;
`ifdef EXEC_QUEUE_BYPASS_EN
         if (mq.size() == 0 && in_valid && !flush) begin
            e_valid = 1'b1;
            e_data  = in_data;
         end
`endif
         check("count", 256'(count), 256'(mq.size()));
         check("in_ready", 256'(in_ready), 256'(mq.size() != DEPTH));
         check("out_valid", 256'(out_valid), 256'(e_valid));
         if (e_valid) check("out_data", 256'(out_data), 256'(e_data));
         check("flags_out", 256'(flags_out), 256'(m_flags));
         check("redirect_valid", 256'(redirect_valid), 256'(m_rv));
         check("redirect_addr", 256'(redirect_addr), 256'(m_ra));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rnd_payload();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[WIDTH-1:0];
   endfunction

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();

      // Fill with out_ready low: count 1..4, then blocked
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(i + 1);
         step();
         check("fill_count", 256'(count), 256'(i + 1));
      end
      check("full_in_ready", 256'(in_ready), 256'(0));
      check("full_head", 256'(out_data), 256'(1));

      // Full + dequeue: no enqueue this cycle, it lands next cycle
      in_data   = WIDTH'(5);
      out_ready = 1'b1;
      step();
      check("full_deq_count", 256'(count), 256'(3));
      check("full_deq_head", 256'(out_data), 256'(2));
      out_ready = 1'b0;
      step();
      check("late_enq_count", 256'(count), 256'(4));
      in_valid = 1'b0;

      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_count", 256'(count), 256'(0));
      check("flush_out_valid", 256'(out_valid), 256'(0));

      // Masked flag updates
      in_valid = 1'b1; in_flags = 7'h41; in_flag_mask = 7'h41;
      step();
      check("flags_41", 256'(flags_out), 256'(7'h41));
      in_flags = 7'h00; in_flag_mask = 7'h01;
      step();
      check("flags_40", 256'(flags_out), 256'(7'h40));
      in_valid = 1'b0; in_flag_mask = '0;

      // Redirect pulse
      in_valid = 1'b1; in_redirect = 1'b1; in_redirect_addr = 32'h0000_1234;
      step();
      check("redir_pulse", 256'(redirect_valid), 256'(1));
      check("redir_addr", 256'(redirect_addr), 256'(32'h0000_1234));
      in_valid = 1'b0; in_redirect = 1'b0;
      step();
      check("redir_drop", 256'(redirect_valid), 256'(0));
      check("redir_hold", 256'(redirect_addr), 256'(32'h0000_1234));

      // Same with flush: dropped entirely
      in_valid = 1'b1; in_redirect = 1'b1; in_redirect_addr = 32'h0000_5678;
      in_flags = 7'h7f; in_flag_mask = 7'h7f; flush = 1'b1;
      step();
      check("flush_redir", 256'(redirect_valid), 256'(0));
      check("flush_redir_cnt", 256'(count), 256'(0));
      check("flush_flags", 256'(flags_out), 256'(7'h40));
      check("flush_raddr", 256'(redirect_addr), 256'(32'h0000_1234));
      in_valid = 1'b0; in_redirect = 1'b0; in_flag_mask = '0; flush = 1'b0;

      // Full-rate pairs; order is checked by the per-cycle compare
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(100 + i);
         step();
         check("pair_count_le1", 256'(count <= 1), 256'(1));
      end
      in_valid = 1'b0;
      step();
      check("pair_drain", 256'(count), 256'(0));

      // Randomized traffic with varying back-pressure
      for (int i = 0; i < 3000; i++) begin
         in_valid         = ($urandom_range(0, 3) != 0);
         out_ready        = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         flush            = ($urandom_range(0, 60) == 0);
         in_data          = rnd_payload();
         in_flags         = FLAGW'($urandom);
         in_flag_mask     = FLAGW'($urandom);
         in_redirect      = ($urandom_range(0, 4) == 0);
         in_redirect_addr = $urandom;
         step();
      end

      // Mid-stream reset with three entries held
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0; in_redirect = 1'b0;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = rnd_payload();
         in_flags = 7'h7f; in_flag_mask = 7'h7f;
         step();
      end
      in_valid = 1'b0; in_flag_mask = '0;
      check("pre_rst_count", 256'(count), 256'(3));
      check("pre_rst_flags", 256'(flags_out), 256'(7'h7f));
      reset = 1'b0;
      #1;
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_count", 256'(count), 256'(0));
      check("rst_flags", 256'(flags_out), 256'(FLAGS_RESET));
      check("rst_in_ready", 256'(in_ready), 256'(1));
      check("rst_rv", 256'(redirect_valid), 256'(0));
      check("rst_ra", 256'(redirect_addr), 256'(0));
      step();
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = WIDTH'(32'h0000_0abc);
`ifdef EXEC_QUEUE_BYPASS_EN
      #1;
      check("byp_valid", 256'(out_valid), 256'(1));
      check("byp_data", 256'(out_data), 256'(32'h0000_0abc));
`endif
      step();
      in_valid = 1'b0;
      check("post_rst_count", 256'(count), 256'(1));
      check("post_rst_head", 256'(out_data), 256'(32'h0000_0abc));
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
